// File: rtl/hazard_unit_pkg.sv
// Shared CPU package for the hazard unit.
//   - hazard_state_t : FSM state encodings (RUN, LSTALL, MWAIT)
//   - LOAD_STALL_MIN/MAX : legal range of the load-use stall length
//   - REG_ZERO : architectural register zero, never a real dependency
//   - clamp_stall() : folds an out-of-range stall length into the legal range
package hazard_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LSTALL = 2'd1,
        ST_MWAIT  = 2'd2
    } hazard_state_t;

    localparam int LOAD_STALL_MIN = 1;
    localparam int LOAD_STALL_MAX = 3;

    localparam logic [4:0] REG_ZERO = 5'd0;

    function automatic int clamp_stall(input int len);
        if (len < LOAD_STALL_MIN) return LOAD_STALL_MIN;
        if (len > LOAD_STALL_MAX) return LOAD_STALL_MAX;
        return len;
    endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating event counter with synchronous clear.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   clr        : synchronous clear, wins over inc
//   inc        : count one event at this edge
//   count      : current value, sticks at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stalls, taken-branch / jump flushes and
// data-memory wait freezes, plus a saturating count of stalled cycles.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   idex_memread, idex_rt      : load in EX and its destination register
//   ifid_rs, ifid_rt           : sources of the instruction in ID
//   branch_taken, jump         : control-flow redirects (EX / ID)
//   dmem_req, dmem_ready       : data-memory access pending / completing
//   clr_stats                  : synchronous clear of stall_count
//   pc_write, ifid_write       : PC and IF/ID update enables
//   en_single                  : control-mux enable, 0 injects a bubble
//   ifid_flush                 : turn IF/ID into a NOP
//   pipe_hold                  : freeze ID/EX, EX/MEM, MEM/WB
//   stall_count                : saturating count of cycles with pc_write=0
//   state_dbg                  : current FSM state (hazard_state_t encoding)
//
// Handshake: none. All outputs are Mealy functions of the registered state and
// the inputs of the current cycle; they take effect at the next rising edge.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             clr_stats,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             en_single,
    output logic             ifid_flush,
    output logic             pipe_hold,
    output logic [CNT_W-1:0] stall_count,
    output logic [1:0]       state_dbg
);

    localparam int         STALL_LEN = clamp_stall(LOAD_STALL);
    // Cycles still owed once the first stall cycle has been spent in RUN.
    localparam logic [1:0] REM_INIT  = 2'(STALL_LEN - 1);

    hazard_state_t state, state_n;
    logic [1:0]    remaining, remaining_n;

    logic mwait;
    logic load_use;
    logic pc_write_c, ifid_write_c, en_single_c, ifid_flush_c, pipe_hold_c;

    assign mwait    = dmem_req & ~dmem_ready;
    assign load_use = idex_memread & (idex_rt != REG_ZERO) &
                      ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            remaining <= 2'd0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
        end
    end

    always_comb begin
        pc_write_c   = 1'b1;
        ifid_write_c = 1'b1;
        en_single_c  = 1'b1;
        ifid_flush_c = 1'b0;
        pipe_hold_c  = 1'b0;
        state_n      = state;
        remaining_n  = remaining;

        case (state)
            // MWAIT with the access completing behaves exactly like RUN.
            ST_RUN, ST_MWAIT: begin
                if (mwait) begin
                    pipe_hold_c  = 1'b1;
                    pc_write_c   = 1'b0;
                    ifid_write_c = 1'b0;
                    state_n      = ST_MWAIT;
                end else if (branch_taken) begin
                    ifid_flush_c = 1'b1;
                    en_single_c  = 1'b0;
                    state_n      = ST_RUN;
                end else if (load_use) begin
                    pc_write_c   = 1'b0;
                    ifid_write_c = 1'b0;
                    en_single_c  = 1'b0;
                    if (STALL_LEN > 1) begin
                        state_n     = ST_LSTALL;
                        remaining_n = REM_INIT;
                    end else begin
                        state_n     = ST_RUN;
                    end
                end else if (jump) begin
                    ifid_flush_c = 1'b1;
                    state_n      = ST_RUN;
                end else begin
                    state_n      = ST_RUN;
                end
            end

            // Redirects are ignored here: the stalled load still owns ID.
            ST_LSTALL: begin
                pc_write_c   = 1'b0;
                ifid_write_c = 1'b0;
                en_single_c  = 1'b0;
                if (mwait) begin
                    pipe_hold_c = 1'b1;
                end else if (remaining == 2'd1) begin
                    remaining_n = 2'd0;
                    state_n     = ST_RUN;
                end else begin
                    remaining_n = remaining - 2'd1;
                end
            end

            default: begin
                state_n     = ST_RUN;
                remaining_n = 2'd0;
            end
        endcase
    end

    // Reset holds the whole front end still without flushing anything.
    assign pc_write   = rst_n & pc_write_c;
    assign ifid_write = rst_n & ifid_write_c;
    assign en_single  = rst_n & en_single_c;
    assign ifid_flush = rst_n & ifid_flush_c;
    assign pipe_hold  = rst_n & pipe_hold_c;
    assign state_dbg  = state;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_stats),
        .inc   (~pc_write),
        .count (stall_count)
    );

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_LSTALL = 2'd1;
  localparam logic [1:0] S_MWAIT  = 2'd2;

  // Output vector order: {pc_write, ifid_write, en_single, ifid_flush, pipe_hold}
  localparam logic [4:0] O_DEF   = 5'b11100;
  localparam logic [4:0] O_LOAD  = 5'b00000;
  localparam logic [4:0] O_BR    = 5'b11010;
  localparam logic [4:0] O_JMP   = 5'b11110;
  localparam logic [4:0] O_MWAIT = 5'b00101;
  localparam logic [4:0] O_RST   = 5'b00000;
  localparam logic [4:0] O_LWAIT = 5'b00001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       idex_memread, branch_taken, jump, dmem_req, dmem_ready, clr_stats;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;

  logic        pw1, iw1, en1, fl1, ph1, pw3, iw3, en3, fl3, ph3;
  logic [15:0] cnt1, cnt3;
  logic [1:0]  st1, st3;
  logic [4:0]  out1, out3;
  assign out1 = {pw1, iw1, en1, fl1, ph1};
  assign out3 = {pw3, iw3, en3, fl3, ph3};

  hazard_unit #(.LOAD_STALL(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .idex_memread(idex_memread), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .branch_taken(branch_taken), .jump(jump),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .clr_stats(clr_stats),
    .pc_write(pw1), .ifid_write(iw1), .en_single(en1), .ifid_flush(fl1),
    .pipe_hold(ph1), .stall_count(cnt1), .state_dbg(st1)
  );

  hazard_unit #(.LOAD_STALL(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .idex_memread(idex_memread), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .branch_taken(branch_taken), .jump(jump),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .clr_stats(clr_stats),
    .pc_write(pw3), .ifid_write(iw3), .en_single(en3), .ifid_flush(fl3),
    .pipe_hold(ph3), .stall_count(cnt3), .state_dbg(st3)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                        input logic [4:0] rt, input logic br, input logic jp,
                        input logic rq, input logic rdy);
    idex_memread = mr; idex_rt = ert; ifid_rs = rs; ifid_rt = rt;
    branch_taken = br; jump = jp; dmem_req = rq; dmem_ready = rdy;
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string      name;
    logic       mr;
    logic [4:0] ert, rs, rt;
    logic       br, jp, rq, rdy;
    logic [4:0] exp_out;
    logic [1:0] exp_st;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{"idle",           0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, O_DEF,   S_RUN};
    vecs[1]  = '{"lu_rs",          1, 5'd8, 5'd8, 5'd3, 0, 0, 0, 0, O_LOAD,  S_RUN};
    vecs[2]  = '{"lu_rt",          1, 5'd9, 5'd4, 5'd9, 0, 0, 0, 0, O_LOAD,  S_RUN};
    vecs[3]  = '{"lu_r0",          1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, O_DEF,   S_RUN};
    vecs[4]  = '{"load_nomatch",   1, 5'd8, 5'd9, 5'd10, 0, 0, 0, 0, O_DEF,  S_RUN};
    vecs[5]  = '{"noload_match",   0, 5'd8, 5'd8, 5'd8, 0, 0, 0, 0, O_DEF,   S_RUN};
    vecs[6]  = '{"branch_vs_lu",   1, 5'd8, 5'd8, 5'd0, 1, 0, 0, 0, O_BR,    S_RUN};
    vecs[7]  = '{"jump",           0, 5'd0, 5'd1, 5'd2, 0, 1, 0, 0, O_JMP,   S_RUN};
    vecs[8]  = '{"jump_vs_lu",     1, 5'd5, 5'd1, 5'd5, 0, 1, 0, 0, O_LOAD,  S_RUN};
    vecs[9]  = '{"mwait_vs_br",    0, 5'd0, 5'd0, 5'd0, 1, 1, 1, 0, O_MWAIT, S_MWAIT};
    vecs[10] = '{"mem_ready",      0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, O_DEF,   S_RUN};
    vecs[11] = '{"branch_jump",    0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, O_BR,    S_RUN};
  end

  // ---------------- test ----------------
  initial begin
    idle();
    clr_stats = 1'b0;
    #2;
    // reset state
    chk("rst_out1", out1, O_RST);
    chk("rst_out3", out3, O_RST);
    chk("rst_state", st1, S_RUN);
    chk("rst_cnt", cnt1, 16'd0);
    do_reset();
    #2;
    chk("post_rst_out", out1, O_DEF);

    // table: each vector applied in RUN, then one idle cycle to settle back
    for (int i = 0; i < 12; i++) begin
      set_in(vecs[i].mr, vecs[i].ert, vecs[i].rs, vecs[i].rt,
             vecs[i].br, vecs[i].jp, vecs[i].rq, vecs[i].rdy);
      #2;
      chk({"out_", vecs[i].name}, out1, vecs[i].exp_out);
      tick();
      chk({"st_", vecs[i].name}, st1, vecs[i].exp_st);
      idle();
      tick();
    end

    // single-cycle load-use stall
    do_reset();
    set_in(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 chk("lu1_c0", out1, O_LOAD);
    tick();
    idle();
    #2 chk("lu1_c1", out1, O_DEF);
    chk("lu1_cnt", cnt1, 16'd1);

    // three-cycle stall, redirects ignored while in LSTALL
    do_reset();
    set_in(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 chk("lu3_c0_out", out3, O_LOAD);
    chk("lu3_c0_st", st3, S_RUN);
    tick();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    #2 chk("lu3_c1_out", out3, O_LOAD);
    chk("lu3_c1_st", st3, S_LSTALL);
    tick();
    idle();
    #2 chk("lu3_c2_out", out3, O_LOAD);
    chk("lu3_c2_st", st3, S_LSTALL);
    tick();
    #2 chk("lu3_c3_out", out3, O_DEF);
    chk("lu3_c3_st", st3, S_RUN);
    chk("lu3_cnt", cnt3, 16'd3);

    // memory wait during LSTALL holds the remaining count
    do_reset();
    set_in(1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 2; c++) begin
      #2 chk("lw_out", out3, O_LWAIT);
      tick();
      chk("lw_st", st3, S_LSTALL);
    end
    idle();
    tick();
    chk("lw_st_rem1", st3, S_LSTALL);
    tick();
    chk("lw_st_done", st3, S_RUN);
    chk("lw_cnt", cnt3, 16'd5);

    // memory wait for 4 cycles, then ready
    do_reset();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      #2 chk("mw_out", out1, O_MWAIT);
      tick();
      chk("mw_st", st1, S_MWAIT);
    end
    dmem_ready = 1'b1;
    #2 chk("mw_rdy_out", out1, O_DEF);
    tick();
    chk("mw_rdy_st", st1, S_RUN);
    chk("mw_cnt", cnt1, 16'd4);

    // MWAIT releasing into a load-use is evaluated as RUN in the same cycle
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    set_in(1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    #2 chk("mw_lu_out3", out3, O_LOAD);
    tick();
    chk("mw_lu_st3", st3, S_LSTALL);
    idle();

    // reset in the second LSTALL cycle
    do_reset();
    set_in(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    chk("rst_mid_pre", st3, S_LSTALL);
    rst_n = 1'b0;
    #1 chk("rst_mid_out", out3, O_RST);
    chk("rst_mid_st", st3, S_RUN);
    tick();
    rst_n = 1'b1;
    #1 chk("rst_rel_out", out3, O_DEF);
    tick();
    chk("rst_rel_st", st3, S_RUN);
    #1 chk("rst_rel_out2", out3, O_DEF);

    // counter saturation and clear
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (65536 + 5) tick();
    chk("sat_cnt", cnt3, 16'hFFFF);
    clr_stats = 1'b1;
    tick();
    chk("clr_cnt", cnt3, 16'd0);
    clr_stats = 1'b0;
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
